// File: rtl/iq_pkg.sv
// Shared definitions for the issue-queue allocation controller: default
// geometry, slot/occupancy types and the "no slot" address marker.
package iq_pkg;

  localparam int IQ_DEPTH        = 16;
  localparam int IQ_DISPATCH_W   = 2;
  localparam int IQ_ISSUE_W      = 4;
  localparam int IQ_AFULL_THRESH = 12;

  localparam int IQ_ADDR_W = $clog2(IQ_DEPTH);
  localparam int IQ_CNT_W  = $clog2(IQ_DEPTH + 1);

  typedef logic [IQ_ADDR_W-1:0] iq_addr_t;
  typedef logic [IQ_CNT_W-1:0]  iq_cnt_t;

  // Address driven on a dispatch lane that was not granted a slot.
  localparam iq_addr_t IQ_ADDR_NONE = '1;

endpackage

// File: rtl/iq_popcount.sv
// Population count of a W-bit vector; used for issued entries and granted
// arrivals.
module iq_popcount #(
  parameter int  W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_cnt
);

  // Sum the set bits of the input vector.
  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < W; k++) begin
      o_cnt = o_cnt + CW'(i_bits[k]);
    end
  end

endmodule

// File: rtl/iq_alloc_ctrl.sv
// Allocation controller for a collapsing issue queue. Combines this cycle's
// departures with in-order arrivals, grants a contiguous prefix of arrivals,
// hands out their slot addresses and tracks registered occupancy and flags.
module iq_alloc_ctrl
  import iq_pkg::*;
#(
  parameter int  DEPTH        = IQ_DEPTH,
  parameter int  DISPATCH_W   = IQ_DISPATCH_W,
  parameter int  ISSUE_W      = IQ_ISSUE_W,
  parameter int  AFULL_THRESH = IQ_AFULL_THRESH,
  localparam int ADDR_W       = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [ISSUE_W-1:0]           issue_vld,
  input  logic [DISPATCH_W-1:0]        disp_vld,
  output logic [DISPATCH_W-1:0]        disp_grant,
  output logic [DISPATCH_W*ADDR_W-1:0] disp_addr,
  output logic                         disp_stall,
  output logic [CNT_W-1:0]             count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         underflow_err
);

  localparam int IC = $clog2(ISSUE_W + 1);
  localparam int GC = $clog2(DISPATCH_W + 1);
  // One extra bit so free space, base address and next count never wrap.
  localparam int XW = CNT_W + 1;

  logic [CNT_W-1:0]    r_count;
  logic                r_empty;
  logic                r_full;
  logic                r_afull;
  logic                r_uf;

  logic [IC-1:0]       w_iss_raw;
  logic [GC-1:0]       w_n_grant;
  logic                w_under;
  logic [XW-1:0]       w_n_iss;
  logic [XW-1:0]       w_free;
  logic [XW-1:0]       w_base;
  logic [XW-1:0]       w_next;
  logic [DISPATCH_W:0] w_chain;

  iq_popcount #(.W(ISSUE_W)) u_iss_cnt (
    .i_bits (issue_vld),
    .o_cnt  (w_iss_raw)
  );

  // Issues beyond the occupied entries are an error and are clamped away.
  assign w_under = 32'(w_iss_raw) > 32'(r_count);
  assign w_n_iss = w_under ? XW'(r_count) : XW'(w_iss_raw);

  // Same-cycle departures make room for same-cycle arrivals; survivors
  // collapse to the bottom, so new entries start right above them.
  assign w_free = XW'(DEPTH) - XW'(r_count) + w_n_iss;
  assign w_base = XW'(r_count) - w_n_iss;

  // Grant chain: a lane is granted only if every lower lane was, so a
  // hole in disp_vld blocks everything above it. Flush kills the chain.
  assign w_chain[0] = ~flush;

  for (genvar i = 0; i < DISPATCH_W; i++) begin : g_lane
    assign w_chain[i+1] = w_chain[i] & disp_vld[i] & (32'(w_free) > 32'(i));
    assign disp_grant[i] = w_chain[i+1];
    assign disp_addr[i*ADDR_W +: ADDR_W] =
      w_chain[i+1] ? ADDR_W'(w_base + XW'(i)) : {ADDR_W{1'b1}};
  end

  iq_popcount #(.W(DISPATCH_W)) u_grant_cnt (
    .i_bits (disp_grant),
    .o_cnt  (w_n_grant)
  );

  assign disp_stall = |(disp_vld & ~disp_grant);

  assign w_next = flush ? '0 : XW'(r_count) + XW'(w_n_grant) - w_n_iss;

  // Occupancy, flags derived from the next count, and sticky underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      r_count <= CNT_W'(w_next);
      r_empty <= (w_next == '0);
      r_full  <= (32'(w_next) == DEPTH);
      r_afull <= (32'(w_next) >= AFULL_THRESH);
      if (!flush && w_under) r_uf <= 1'b1;
    end
  end

  assign count         = r_count;
  assign empty         = r_empty;
  assign full          = r_full;
  assign almost_full   = r_afull;
  assign underflow_err = r_uf;

endmodule

// File: tb/tb_iq_alloc_ctrl.sv
// Bench for iq_alloc_ctrl: two instances (16/2/4 and 8/4/2) driven with
// directed and random traffic, each compared against an occupancy model.
module tb_iq_alloc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: DEPTH=16, DISPATCH_W=2, ISSUE_W=4, AFULL=12
  logic       a_fl;
  logic [3:0] a_iv;
  logic [1:0] a_dv;
  logic [1:0] a_g;
  logic [7:0] a_ad;
  logic       a_st;
  logic [4:0] a_cnt;
  logic       a_emp, a_ful, a_af, a_uf;

  // Instance B: DEPTH=8, DISPATCH_W=4, ISSUE_W=2, AFULL=6
  logic        b_fl;
  logic [1:0]  b_iv;
  logic [3:0]  b_dv;
  logic [3:0]  b_g;
  logic [11:0] b_ad;
  logic        b_st;
  logic [3:0]  b_cnt;
  logic        b_emp, b_ful, b_af, b_uf;

  int n_chk  = 0;
  int n_pass = 0;

  int DEP[2] = '{16, 8};
  int DW[2]  = '{2, 4};
  int AW[2]  = '{4, 3};
  int THR[2] = '{12, 6};

  int mcnt[2];
  bit muf[2];
  int nxt[2];
  bit nuf[2];

  iq_alloc_ctrl #(.DEPTH(16), .DISPATCH_W(2), .ISSUE_W(4), .AFULL_THRESH(12)) u_a (
    .clk(clk), .rst(rst), .flush(a_fl), .issue_vld(a_iv), .disp_vld(a_dv),
    .disp_grant(a_g), .disp_addr(a_ad), .disp_stall(a_st), .count(a_cnt),
    .empty(a_emp), .full(a_ful), .almost_full(a_af), .underflow_err(a_uf)
  );

  iq_alloc_ctrl #(.DEPTH(8), .DISPATCH_W(4), .ISSUE_W(2), .AFULL_THRESH(6)) u_b (
    .clk(clk), .rst(rst), .flush(b_fl), .issue_vld(b_iv), .disp_vld(b_dv),
    .disp_grant(b_g), .disp_addr(b_ad), .disp_stall(b_st), .count(b_cnt),
    .empty(b_emp), .full(b_ful), .almost_full(b_af), .underflow_err(b_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Expected behaviour from the queue rules: clamp issues, compute free
  // space, grant the valid prefix up to free space, stack new entries on
  // top of the survivors.
  task automatic model_chk(input int d, input logic [31:0] iv, input logic [31:0] dv,
                           input logic fl, input logic [31:0] g, input logic [31:0] ad,
                           input logic [31:0] st, input logic [31:0] cn,
                           input logic [31:0] em, input logic [31:0] fu,
                           input logic [31:0] af, input logic [31:0] uf);
    string nm;
    int pop, niss, free, pre, ng;
    logic [31:0] eg, ea, lane;
    nm   = (d == 0) ? "A" : "B";
    pop  = $countones(iv);
    niss = (pop > mcnt[d]) ? mcnt[d] : pop;
    free = DEP[d] - mcnt[d] + niss;
    pre  = 0;
    while (pre < DW[d] && dv[pre]) pre++;
    ng   = fl ? 0 : ((pre < free) ? pre : free);
    eg   = (32'd1 << ng) - 32'd1;
    ea   = '0;
    for (int i = 0; i < DW[d]; i++) begin
      lane = (i < ng) ? 32'(mcnt[d] - niss + i) : ((32'd1 << AW[d]) - 32'd1);
      ea   = ea | (lane << (i * AW[d]));
    end
    chk({nm, ".grant"}, g, eg);
    chk({nm, ".addr"}, ad, ea);
    chk({nm, ".stall"}, st, 32'(|(dv & ~eg)));
    chk({nm, ".count"}, cn, 32'(mcnt[d]));
    chk({nm, ".empty"}, em, 32'(mcnt[d] == 0));
    chk({nm, ".full"}, fu, 32'(mcnt[d] == DEP[d]));
    chk({nm, ".afull"}, af, 32'(mcnt[d] >= THR[d]));
    chk({nm, ".underflow"}, uf, 32'(muf[d]));
    nxt[d] = fl ? 0 : mcnt[d] + ng - niss;
    nuf[d] = muf[d] | (!fl && (pop > mcnt[d]));
  endtask

  // One clock of traffic on both instances; entered just after a rising edge.
  task automatic cyc(input int iva, input int dva, input int fla,
                     input int ivb, input int dvb, input int flb);
    a_iv = 4'(iva); a_dv = 2'(dva); a_fl = 1'(fla);
    b_iv = 2'(ivb); b_dv = 4'(dvb); b_fl = 1'(flb);
    #2;
    model_chk(0, 32'(a_iv), 32'(a_dv), a_fl, 32'(a_g), 32'(a_ad), 32'(a_st),
              32'(a_cnt), 32'(a_emp), 32'(a_ful), 32'(a_af), 32'(a_uf));
    model_chk(1, 32'(b_iv), 32'(b_dv), b_fl, 32'(b_g), 32'(b_ad), 32'(b_st),
              32'(b_cnt), 32'(b_emp), 32'(b_ful), 32'(b_af), 32'(b_uf));
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = nxt[d];
      muf[d]  = nuf[d];
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".A.count"}, 32'(a_cnt), 32'd0);
    chk({tag, ".A.flags"}, {28'd0, a_emp, a_ful, a_af, a_uf}, 32'h8);
    chk({tag, ".B.count"}, 32'(b_cnt), 32'd0);
    chk({tag, ".B.flags"}, {28'd0, b_emp, b_ful, b_af, b_uf}, 32'h8);
  endtask

  // Pulse reset between clock edges and confirm it acts without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state(tag);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      muf[d]  = 1'b0;
    end
  endtask

  initial begin
    a_iv = '0; a_dv = '0; a_fl = 1'b0;
    b_iv = '0; b_dv = '0; b_fl = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      muf[d]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Fill from empty: A two per cycle up to 16, B four per cycle then stalls.
    repeat (8) cyc(0, 3, 0, 0, 15, 0);
    // Full with one issue: one arrival granted at the top slot.
    cyc(1, 3, 0, 1, 15, 0);
    // Full with no issues: everything stalls.
    cyc(0, 3, 0, 0, 15, 0);
    cyc(0, 0, 1, 0, 0, 1);

    // A to 5, B to 3, then mixed issue/dispatch.
    cyc(0, 3, 0, 0, 1, 0);
    cyc(0, 3, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(11, 3, 0, 3, 3, 0);
    cyc(0, 0, 1, 0, 0, 1);

    // Underflow: over-issue, then keep traffic going so the flag must stick.
    cyc(0, 3, 0, 0, 1, 0);
    cyc(15, 0, 0, 3, 0, 0);
    cyc(15, 3, 0, 0, 15, 0);
    cyc(0, 3, 0, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // Flush at A=9 with arrivals offered.
    cyc(5, 3, 1, 1, 15, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Reach A=7 and reset between edges.
    cyc(0, 3, 0, 0, 3, 0);
    cyc(0, 3, 0, 0, 3, 0);
    cyc(0, 3, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    async_reset("areset");

    // Random traffic, mostly legal prefixes with occasional holes.
    for (int k = 0; k < 400; k++) begin
      int ra, rb, da, db;
      ra = $urandom_range(0, 2);
      rb = $urandom_range(0, 4);
      da = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3))  : (1 << ra) - 1;
      db = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : (1 << rb) - 1;
      cyc(int'($urandom_range(0, 15) & $urandom_range(0, 15)), da,
          int'($urandom_range(0, 19) == 0),
          int'($urandom_range(0, 3) & $urandom_range(0, 3)), db,
          int'($urandom_range(0, 19) == 0));
      if (k % 97 == 50) async_reset("rnd_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iq_alloc_ctrl.md
Name: iq_alloc_ctrl

Overview:
- Allocation controller for a collapsing (compacting) issue queue.
- Every cycle it combines up to ISSUE_W departures with up to DISPATCH_W in-order arrivals and tracks occupancy in a count register.
- It grants a contiguous prefix of arrivals and gives each granted arrival its queue slot address.
- Sits between the dispatch stage and the queue entry array. Generalises the fixed 16-entry, 2-in/4-out allocator with parametrised sizes, backpressure, flush, thresholds and error detection.

Parameters:
DEPTH, 16, number of queue entries (2..256).
DISPATCH_W, 2, new instructions offered per cycle (1..8).
ISSUE_W, 4, entries removed (issued) per cycle (1..8).
AFULL_THRESH, 12, occupancy at or above which almost_full asserts.
ADDR_W, $clog2(DEPTH), slot address width (derived; do not override).
CNT_W, $clog2(DEPTH+1), occupancy width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous pipeline flush; empties queue accounting
issue_vld  in  ISSUE_W  one bit per entry leaving the queue this cycle
disp_vld  in  DISPATCH_W  arriving instructions; must be a contiguous prefix from bit 0
disp_grant  out  DISPATCH_W  per-slot acceptance (combinational)
disp_addr  out  DISPATCH_W*ADDR_W  slot address per arrival; all-ones when not granted
disp_stall  out  1  some valid arrival not granted this cycle
count  out  CNT_W  registered occupancy
empty  out  1  count == 0 (registered)
full  out  1  count == DEPTH (registered)
almost_full  out  1  count >= AFULL_THRESH (registered)
underflow_err  out  1  sticky: more issues than occupied entries

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port rst. Reset sets count = 0, underflow_err = 0, empty = 1, full = 0, almost_full = 0.
- Per-cycle issue count:
  - n_iss = popcount(issue_vld), then clamped to count.
  - If popcount exceeds count, underflow_err sets and holds until rst.
- Free space: free = DEPTH - count + n_iss. Same-cycle issues free space for same-cycle arrivals.
- Grant: disp_grant[i] = disp_vld[i] && (all lower valid slots granted) && (i < free). Slots are granted strictly in order; no holes.
- Address:
  - disp_addr[i] = count - n_iss + i when granted, else {ADDR_W{1'b1}}.
  - Compute in CNT_W+1 bits. The result is never >= DEPTH when granted.
- Stall: disp_stall = |(disp_vld & ~disp_grant).
- Next count: count + n_grant - n_iss, where n_grant = popcount(disp_grant).
- Flush:
  - Forces disp_grant = 0 and disp_addr = all-ones that cycle.
  - Next count = 0 regardless of issue_vld.
  - underflow_err is not checked or altered in a flush cycle.
- Flags: empty, full and almost_full are registered, updated from next count in the same edge as count.
- Non-prefix disp_vld (for example 2'b10) is illegal. Design behaviour for it: no grant beyond the first invalid slot, so 2'b10 grants nothing.
- Latency: grants and addresses are combinational from registered count plus current inputs. Occupancy reflects a cycle's events one clock later.
- Boundaries:
  - full with no issues: all arrivals stalled.
  - full with k issues: up to k arrivals granted at addresses DEPTH-k onward.
  - empty with issue_vld nonzero: underflow_err = 1, count stays 0 plus grants.
- Reset asserted mid-cycle clears immediately, with no dependence on the clock.

Decomposition:
- Shared package iq_pkg:
  - IQ_DEPTH, IQ_DISPATCH_W, IQ_ISSUE_W defaults.
  - iq_addr_t / iq_cnt_t typedefs.
  - IQ_ADDR_NONE constant (all-ones).
- One sub-module: iq_popcount, parametrised input width, used for both issue_vld and disp_grant counting.
- Prefix-grant and address generation stay inline as a generate loop.

Test Plan:
- Reset, then disp_vld=2'b11, issue_vld=0 for 8 cycles:
  - Addresses (0,1), (2,3), ... (14,15).
  - count ends at 16; full=1, almost_full asserted from count 12.
- Full queue, disp_vld=2'b11, issue_vld=4'b0001:
  - grant=2'b01, addr0=15, disp_stall=1, count stays 16.
- count=5, issue_vld=4'b1011, disp_vld=2'b11:
  - addrs 2 and 3; next count=4.
- count=2, issue_vld=4'b1111:
  - underflow_err=1 next cycle and stays 1 through later traffic.
  - count=0 (plus grants that cycle); only rst clears underflow_err.
- count=9, flush=1 with disp_vld=2'b11:
  - grant=0, addrs all-ones; next count=0, empty=1.
- rst asserted asynchronously between edges at count=7:
  - count=0 and flags at reset values immediately.
  - Repeat the scenarios with DEPTH=8, DISPATCH_W=4, ISSUE_W=2.
